// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a prefetch FIFO, valid/ready output and redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned redirect target yields one marker entry and halts fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req,
  output logic [31:0] rom_addr_out,
  input  logic [31:0] rom_data_in,
  input  logic        rom_valid_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        inst_misalign_out
`endif
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          halted;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   pc_q   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   demand;
  logic          push;
  logic          pop;
  logic [31:0]   target;
`ifdef FETCH_ALIGN_CHECK_EN
  logic          mis_q [FIFO_DEPTH];
  logic          misaligned;
  assign misaligned = redirect_pc[1:0] != 2'b00;
`endif

  // An outstanding request reserves a slot, so a full FIFO can never be overrun.
  assign demand  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign rom_req = !rst && !redirect_valid && !halted && (demand < DEPTH_L);
  assign rom_addr_out = fetch_pc;

  assign inst_valid  = count != '0;
  assign inst_out    = inst_valid ? data_q[rd_ptr] : '0;
  assign inst_pc_out = inst_valid ? pc_q[rd_ptr]   : '0;
`ifdef FETCH_ALIGN_CHECK_EN
  assign inst_misalign_out = inst_valid ? mis_q[rd_ptr] : 1'b0;
`endif

  assign push   = inflight && rom_valid_in && !redirect_valid;
  assign pop    = inst_valid && inst_ready && !redirect_valid;
  assign target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      halted      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
        mis_q[i]  <= 1'b0;
`endif
      end
    end else if (redirect_valid) begin
      fetch_pc <= target;
      inflight <= 1'b0;
      halted   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (misaligned) begin
        data_q[0] <= '0;
        pc_q[0]   <= redirect_pc;
        mis_q[0]  <= 1'b1;
        wr_ptr    <= PW'(1);
        count     <= CW'(1);
        halted    <= 1'b1;
      end
`endif
    end else begin
      inflight <= rom_req;
      if (rom_req) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (push) begin
        data_q[wr_ptr] <= rom_data_in;
        pc_q[wr_ptr]   <= inflight_pc;
`ifdef FETCH_ALIGN_CHECK_EN
        mis_q[wr_ptr]  <= 1'b0;
`endif
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: queue-based reference model plus directed literal checks.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_req;
  logic [31:0] rom_addr_out;
  logic [31:0] rom_data_in;
  logic        rom_valid_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        inst_misalign_out;
`endif

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rom_req(rom_req), .rom_addr_out(rom_addr_out),
    .rom_data_in(rom_data_in), .rom_valid_in(rom_valid_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc_out(inst_pc_out)
`ifdef FETCH_ALIGN_CHECK_EN
    , .inst_misalign_out(inst_misalign_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_ipc;
  logic        m_infl;
  logic        m_halt;
  logic [63:0] dut_pops[$];
  logic        s_req;
  logic [31:0] s_addr;
  bit          stray_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_pop(string nm, int idx, logic [31:0] pc, logic [31:0] data);
    if (idx < dut_pops.size()) begin
      chk({nm, "_pc"}, dut_pops[idx][63:32], pc);
      chk({nm, "_data"}, dut_pops[idx][31:0], data);
    end else begin
      total++;
      bad++;
      $display("FAIL %s: only %0d instructions delivered, needed index %0d", nm, dut_pops.size(), idx);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_fpc  = RPC;
    m_ipc  = '0;
    m_infl = 1'b0;
    m_halt = 1'b0;
  endfunction

  function automatic logic exp_req();
    return !rst && !redirect_valid && !m_halt && (mq.size() + int'(m_infl) < int'(DEPTH));
  endfunction

  function automatic void model_step();
    logic req;
    if (rst) begin
      model_reset();
      return;
    end
    req = exp_req();
    if (redirect_valid) begin
      mq.delete();
      m_infl = 1'b0;
      m_halt = 1'b0;
      m_fpc  = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        mq.push_back('{32'h0, redirect_pc, 1'b1});
        m_halt = 1'b1;
      end
`endif
    end else begin
      if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
      if (m_infl && rom_valid_in) mq.push_back('{m_ipc >> 2, m_ipc, 1'b0});
      m_infl = req;
      if (req) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end
    end
  endfunction

  function automatic void compare();
    logic r;
    r = exp_req();
    chk("rom_req", {31'b0, rom_req}, {31'b0, r});
    if (r) chk("rom_addr", rom_addr_out, m_fpc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0 && inst_valid) begin
      chk("inst_out", inst_out, mq[0].data);
      chk("inst_pc", inst_pc_out, mq[0].pc);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("inst_mis", {31'b0, inst_misalign_out}, {31'b0, mq[0].mis});
`endif
    end
  endfunction

  // One clock: compare mid-low-phase, advance the model at the edge, present ROM response after.
  task automatic cycle();
    #1;
    if (rst) model_reset();
    compare();
    if (inst_valid && inst_ready && !redirect_valid && !rst)
      dut_pops.push_back({inst_pc_out, inst_out});
    s_req  = rom_req;
    s_addr = rom_addr_out;
    @(posedge clk);
    model_step();
    @(negedge clk);
    rom_valid_in = s_req;
    rom_data_in  = s_req ? (s_addr >> 2) : $urandom;
    if (!s_req && stray_en && $urandom_range(0, 9) == 0) rom_valid_in = 1'b1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect(logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1; rom_valid_in = 1'b0; rom_data_in = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_req", {31'b0, rom_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_pc", inst_pc_out, 32'd0);
    run(3);

    // Reset release: streaming with decode always ready.
    rst = 1'b0; inst_ready = 1'b1;
    #1 chk("first_req", {31'b0, rom_req}, 32'd1);
    chk("first_addr", rom_addr_out, RPC);
    chk("first_nvalid", {31'b0, inst_valid}, 32'd0);
    cycle();
    #1 chk("c1_nvalid", {31'b0, inst_valid}, 32'd0);
    cycle();
    #1 chk("c2_valid", {31'b0, inst_valid}, 32'd1);
    run(10);
    for (int k = 0; k < 4; k++) chk_pop("stream", k, 32'(4 * k), 32'(k));

    // Decode stall: FIFO fills to capacity and requests stop.
    inst_ready = 1'b0;
    base = dut_pops.size();
    run(10);
    #1 chk("stall_valid", {31'b0, inst_valid}, 32'd1);
    chk("stall_req", {31'b0, rom_req}, 32'd0);
    chk("stall_nopop", 32'(dut_pops.size()), 32'(base));

    // Free one slot so a response is in flight, then redirect on its arrival cycle.
    inst_ready = 1'b1; cycle();
    inst_ready = 1'b0; cycle();
    redirect(32'h0000_0100);
    inst_ready = 1'b1;
    #1 chk("rd1_req", {31'b0, rom_req}, 32'd1);
    chk("rd1_addr", rom_addr_out, 32'h0000_0100);
    chk("rd1_nvalid", {31'b0, inst_valid}, 32'd0);
    cycle();
    #1 chk("rd2_nvalid", {31'b0, inst_valid}, 32'd0);
    cycle();
    #1 chk("rd3_valid", {31'b0, inst_valid}, 32'd1);
    chk("rd3_pc", inst_pc_out, 32'h0000_0100);
    chk("rd3_data", inst_out, 32'd64);
    run(6);

    // Address wrap at the top of the space.
    redirect(32'hFFFF_FFF8);
    base = dut_pops.size();
    run(8);
    chk_pop("wrap0", base,     32'hFFFF_FFF8, 32'h3FFF_FFFE);
    chk_pop("wrap1", base + 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    chk_pop("wrap2", base + 2, 32'h0000_0000, 32'h0000_0000);

    // Misaligned redirect target.
    redirect(32'h0000_0102);
    base = dut_pops.size();
`ifdef FETCH_ALIGN_CHECK_EN
    #1 chk("mis_valid", {31'b0, inst_valid}, 32'd1);
    chk("mis_pc", inst_pc_out, 32'h0000_0102);
    chk("mis_flag", {31'b0, inst_misalign_out}, 32'd1);
    chk("mis_inst", inst_out, 32'd0);
    chk("mis_req", {31'b0, rom_req}, 32'd0);
    run(6);
    #1 chk("mis_halt_req", {31'b0, rom_req}, 32'd0);
    chk("mis_count", 32'(dut_pops.size()), 32'(base + 1));
`else
    run(6);
    chk_pop("mis_forced", base, 32'h0000_0100, 32'd64);
`endif
    redirect(32'h0000_0200);
    run(5);

    // Reset mid-stream with a request outstanding; a stray response follows.
    rst = 1'b1;
    #1 chk("mrst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mrst_req", {31'b0, rom_req}, 32'd0);
    chk("mrst_inst", inst_out, 32'd0);
    cycle();
    rst = 1'b0;
    rom_valid_in = 1'b1; rom_data_in = 32'hDEAD_BEEF;
    #1 chk("mrst_restart_req", {31'b0, rom_req}, 32'd1);
    chk("mrst_restart_addr", rom_addr_out, RPC);
    cycle();
    #1 chk("mrst_stray_ignored", {31'b0, inst_valid}, 32'd0);
    cycle();
    #1 chk("mrst_first_pc", inst_pc_out, RPC);
    chk("mrst_first_data", inst_out, 32'd0);
    run(4);

    // Randomized traffic.
    stray_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; cycle(); rst = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0:       redirect($urandom & 32'hFFFF_FFFC);
          1:       redirect(32'hFFFF_FFF0 | ($urandom & 32'hC));
          2:       redirect(32'($urandom_range(0, 255)) << 2);
          default: redirect($urandom);
        endcase
      end else begin
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
